// File: rtl/skl_pipe_adder.sv
// Pipelined Sklansky parallel-prefix adder with valid/ready handshake and global stall.
// Define SKL_OVF_EN to add the registered signed-overflow output ovf.
module skl_pipe_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic             cin,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SKL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int L = $clog2(WIDTH);

    logic             advance;
    logic [L:0]       vld;
    logic [L:0]       ck;
    logic [WIDTH-1:0] gg [0:L];
    logic [WIDTH-1:0] pp [0:L];
    logic [WIDTH-1:0] pk [0:L];

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance & ~flush;

    // gg/pp at index i hold group generate/propagate after prefix level i;
    // pk keeps the raw bit propagates for the final sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld       <= '0;
            ck        <= '0;
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
`ifdef SKL_OVF_EN
            ovf       <= 1'b0;
`endif
            for (int lv = 0; lv <= L; lv++) begin
                gg[lv] <= '0;
                pp[lv] <= '0;
                pk[lv] <= '0;
            end
        end else if (flush) begin
            vld       <= '0;
            out_valid <= 1'b0;
        end else if (advance) begin
            // cin is folded into bit 0 so every group generate already includes it
            vld[0] <= in_valid;
            ck[0]  <= cin;
            pk[0]  <= x1 ^ x2;
            pp[0]  <= x1 ^ x2;
            gg[0]  <= {x1[WIDTH-1:1] & x2[WIDTH-1:1],
                       (x1[0] & x2[0]) | ((x1[0] ^ x2[0]) & cin)};

            for (int lv = 1; lv <= L; lv++) begin
                vld[lv] <= vld[lv-1];
                ck[lv]  <= ck[lv-1];
                pk[lv]  <= pk[lv-1];
                for (int j = 0; j < WIDTH; j++) begin
                    // upper half of each 2^lv block combines with the top bit of the lower half
                    if (((j >> (lv - 1)) & 1) != 0) begin
                        gg[lv][j] <= gg[lv-1][j] |
                                     (pp[lv-1][j] & gg[lv-1][((j >> (lv - 1)) << (lv - 1)) - 1]);
                        pp[lv][j] <= pp[lv-1][j] & pp[lv-1][((j >> (lv - 1)) << (lv - 1)) - 1];
                    end else begin
                        gg[lv][j] <= gg[lv-1][j];
                        pp[lv][j] <= pp[lv-1][j];
                    end
                end
            end

            out_valid <= vld[L];
            if (vld[L]) begin
                s    <= pk[L] ^ {gg[L][WIDTH-2:0], ck[L]};
                cout <= gg[L][WIDTH-1];
`ifdef SKL_OVF_EN
                ovf  <= gg[L][WIDTH-2] ^ gg[L][WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_skl_pipe_adder.sv
// Directed bench for skl_pipe_adder at WIDTH=8: latency, carry corners, stall, flush, reset.
module tb_skl_pipe_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         cin;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
`ifdef SKL_OVF_EN
    logic         ovf;
`endif

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    skl_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .cin       (cin),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef SKL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 1'b0;
        x1       = '0;
        x2       = '0;
        cin      = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        #2;
        nvec++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        nvec++; if (in_ready !== 1'b1) begin nbad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        nvec++; if (s !== 8'h00) begin nbad++; $display("FAIL reset_s got=%h want=00", s); end
        nvec++; if (cout !== 1'b0) begin nbad++; $display("FAIL reset_cout got=%b want=0", cout); end
`ifdef SKL_OVF_EN
        nvec++; if (ovf !== 1'b0) begin nbad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
        step();
        step();
        nvec++; if (in_ready !== 1'b1) begin nbad++; $display("FAIL reset_hold_in_ready got=%b want=1", in_ready); end
        rst = 1'b0;
        step();
        nvec++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL post_reset_out_valid got=%b want=0", out_valid); end
        nvec++; if (in_ready !== 1'b1) begin nbad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic;
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic         vc [4];
        logic [W-1:0] es [4];
        logic         ec [4];
        logic         eo [4];
        int lat;
        va = '{8'hFF, 8'h7F, 8'hFF, 8'h80};
        vb = '{8'h01, 8'h01, 8'hFF, 8'h80};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0};
        es = '{8'h00, 8'h80, 8'hFF, 8'h00};
        ec = '{1'b1, 1'b0, 1'b1, 1'b1};
        eo = '{1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1;
            x1 = va[n];
            x2 = vb[n];
            cin = vc[n];
            step();
            idle_inputs();
            lat = 0;
            while (!out_valid && lat < 10) begin
                step();
                lat++;
            end
            nvec++; if (lat !== 4) begin nbad++; $display("FAIL basic_latency[%0d] got=%0d want=4", n, lat); end
            nvec++; if (s !== es[n]) begin nbad++; $display("FAIL basic_s[%0d] got=%h want=%h", n, s, es[n]); end
            nvec++; if (cout !== ec[n]) begin nbad++; $display("FAIL basic_cout[%0d] got=%b want=%b", n, cout, ec[n]); end
`ifdef SKL_OVF_EN
            nvec++; if (ovf !== eo[n]) begin nbad++; $display("FAIL basic_ovf[%0d] got=%b want=%b", n, ovf, eo[n]); end
`else
            if (eo[n] === 1'bx) $display("note: unexpected table entry");
`endif
        end
        step();
    endtask

    task automatic test_back_to_back;
        int nb;
        int rcv;
        int c;
        logic exp_rdy;
        logic acc;
        logic xfer;
        logic [W:0] got;
        logic [W:0] exp;
        nb  = 0;
        rcv = 0;
        c   = 0;
        while (c < 80 && rcv < 10) begin
            in_valid  = (nb < 10);
            x1        = W'(nb);
            x2        = W'(2 * nb);
            cin       = nb[0];
            out_ready = !(c >= 6 && c <= 9);
            exp_rdy   = !(c >= 6 && c <= 9);
            #1;
            nvec++; if (in_ready !== exp_rdy) begin nbad++; $display("FAIL b2b_in_ready[c%0d] got=%b want=%b", c, in_ready, exp_rdy); end
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            got  = {cout, s};
            if (xfer) begin
                exp = (W+1)'(3 * rcv + (rcv & 1));
                nvec++; if (got !== exp) begin nbad++; $display("FAIL b2b_result[%0d] got=%h want=%h", rcv, got, exp); end
                rcv++;
            end
            if (acc) nb++;
            step();
            c++;
        end
        idle_inputs();
        out_ready = 1'b1;
        nvec++; if (rcv !== 10) begin nbad++; $display("FAIL b2b_count got=%0d want=10", rcv); end
        step();
        step();
        nvec++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL b2b_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        int seen;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x1 = W'(i + 1);
            x2 = 8'h01;
            step();
        end
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            step();
        end
        nvec++; if (seen !== 0) begin nbad++; $display("FAIL rstmid_ghost got=%0d want=0", seen); end
        in_valid = 1'b1;
        x1 = 8'h10;
        x2 = 8'h20;
        step();
        idle_inputs();
        lat = 0;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        nvec++; if (lat !== 4) begin nbad++; $display("FAIL rstmid_latency got=%0d want=4", lat); end
        nvec++; if (s !== 8'h30) begin nbad++; $display("FAIL rstmid_s got=%h want=30", s); end
        nvec++; if (cout !== 1'b0) begin nbad++; $display("FAIL rstmid_cout got=%b want=0", cout); end
        step();
    endtask

    task automatic test_flush;
        int seen;
        out_ready = 1'b1;
        in_valid = 1'b1;
        x1 = 8'h11; x2 = 8'h22;
        step();
        x1 = 8'h33; x2 = 8'h44;
        step();
        x1 = 8'h55; x2 = 8'h11;
        flush = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b0) begin nbad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
        step();
        idle_inputs();
        #1;
        nvec++; if (in_ready !== 1'b1) begin nbad++; $display("FAIL flush_after_in_ready got=%b want=1", in_ready); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            step();
        end
        nvec++; if (seen !== 0) begin nbad++; $display("FAIL flush_ghost got=%0d want=0", seen); end
    endtask

    task automatic test_random;
        logic [W:0] q[$];
        logic [W:0] got;
        logic [W:0] exp;
        logic acc;
        logic xfer;
        int sent;
        int rcv;
        int c;
        sent = 0;
        rcv  = 0;
        c    = 0;
        while ((sent < 300 || rcv < sent) && c < 3000) begin
            in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
            x1        = W'($urandom);
            x2        = W'($urandom);
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            got  = {cout, s};
            if (xfer) begin
                if (q.size() == 0) begin
                    nvec++; nbad++;
                    $display("FAIL rand_extra got=%h want=none", got);
                end else begin
                    exp = q.pop_front();
                    nvec++; if (got !== exp) begin nbad++; $display("FAIL rand_result[%0d] got=%h want=%h", rcv, got, exp); end
                end
                rcv++;
            end
            if (acc) begin
                q.push_back({1'b0, x1} + {1'b0, x2} + {{W{1'b0}}, cin});
                sent++;
            end
            step();
            c++;
        end
        idle_inputs();
        nvec++; if (rcv !== 300) begin nbad++; $display("FAIL rand_count got=%0d want=300", rcv); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/skl_pipe_adder.md
SKL_PIPE_ADDER -- requirements
Module: skl_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand width; legal values 4, 8, 16, 32, 64 (power of two).
REQ-002 Derived L = log2(WIDTH), the number of Sklansky prefix levels; not user-overridable.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  pipeline accepts a beat this cycle.
REQ-007 x1, x2  input  WIDTH each  operands.
REQ-008 cin  input  1  carry-in.
REQ-009 flush  input  1  synchronous discard of all in-flight beats.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 s  output  WIDTH  sum of x1 + x2 + cin.
REQ-013 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-014 Accept occurs on a rising edge where in_valid=1 and in_ready=1; transfer out occurs on an edge where out_valid=1 and out_ready=1.
REQ-015 Pipeline stages:
- stage 0 registers p=x1^x2, g=x1&x2 and cin;
- bit-0 generate is g0|(p0&cin);
- stages 1..L each register one Sklansky prefix level (group span 2^(i-1) at level i);
- stage L+1 registers s, cout and out_valid.
REQ-016 Latency: a beat accepted at edge k drives out_valid=1 with its result after edge k+L+1 (WIDTH=8 gives 4 cycles), provided there is no stall.
REQ-017 Global advance: advance = ~out_valid | out_ready; every stage updates only when advance=1; in_ready = advance.
- Bubbles are not compressed.
- in_ready does not depend on in_valid.
REQ-018 A stage slot holds a valid bit; a stage whose predecessor is invalid loads valid=0 on advance; out_valid is the last stage's valid bit.
REQ-019 Throughput is one beat per cycle while out_ready=1; results leave strictly in acceptance order.
REQ-020 s[i] = p[i] ^ carry-into-bit-i, with carry-into-bit-0 = cin; cout = group generate of bits WIDTH-1..0 including cin.
REQ-021 s and cout are exact modulo 2^WIDTH for all operand values, including all-ones + all-ones + cin=1 (s=all-ones, cout=1).
REQ-022 When out_valid=0, s and cout hold their last value and carry no meaning.
REQ-023 flush=1 at an edge clears every valid bit, including out_valid, and overrides advance.
- in_ready=0 in a cycle with flush=1.
- A beat offered in that cycle is not accepted.
REQ-024 Simultaneous transfer out and accept on the same edge is legal and loses no beat.

Reset
REQ-025 rst=1 immediately clears all stage valid bits and out_valid; s, cout, and every p/g register reset to 0.
REQ-026 in_ready reads 1 during and after reset, since out_valid=0.
REQ-027 Reset mid-operation discards every in-flight beat; no result for a pre-reset beat ever appears.

Configuration
REQ-028 Macro SKL_OVF_EN:
- when defined, adds output port ovf (1 bit) = carry-into-bit-(WIDTH-1) ^ cout, which flags two's-complement signed overflow;
- ovf is registered in stage L+1 alongside s and resets to 0;
- when undefined, the port and its logic are absent and all other behaviour is identical.

Verification (WIDTH=8)
REQ-029 Accept x1=0xFF, x2=0x01, cin=0, out_ready=1 -> exactly 4 cycles later out_valid=1, s=0x00, cout=1, and ovf=0 if SKL_OVF_EN.
REQ-030 Accept x1=0x7F, x2=0x01, cin=0 -> s=0x80, cout=0, ovf=1 (SKL_OVF_EN).
REQ-031 Stream 10 back-to-back beats (i, 2i, cin=i&1), holding out_ready=0 for cycles 6-9 -> in_ready=0 while stalled, no beat lost or duplicated, and results appear in order.
REQ-032 Accept 3 beats then assert rst for 1 cycle mid-flight -> out_valid stays 0 afterwards, and a new beat 0x10+0x20 returns s=0x30 after 4 cycles.
REQ-033 Accept 2 beats, assert flush with in_valid=1 on the next edge -> no outputs for flushed beats, the offered beat is not accepted, and in_ready=1 the following cycle.
REQ-034 Random 10^5 beats with random out_ready, repeated for WIDTH=4/16/64 -> every {cout,s} equals the reference sum x1+x2+cin.
